// File: rtl/execute_pipe.sv
// execute_pipe: single-issue execute stage with valid/ready handshake and registered outputs.
// Optional iterative shift-add multiplier (opcode 16) is built only when EXEC_MUL_EN is defined.
module execute_pipe #(
  parameter int DATA_W    = 16,
  parameter int IMM_W     = 7,
  parameter int REG_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           op,
  input  logic [DATA_W-1:0]    rs1_data,
  input  logic [DATA_W-1:0]    rs2_data,
  input  logic [DATA_W-1:0]    npc,
  input  logic [REG_IDX_W-1:0] dest_in,
  input  logic [IMM_W-1:0]     imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4:0]           op_out,
  output logic [REG_IDX_W-1:0] dest_out,
  output logic [DATA_W-1:0]    result,
  output logic [DATA_W-1:0]    store_data,
  output logic                 reg_we,
  output logic                 branch_taken,
  output logic [DATA_W-1:0]    target,
  output logic                 zf,
  output logic                 gf,
  output logic                 lf
);
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_ADD    = 5'd2;
  localparam logic [4:0] OP_ADDI   = 5'd3;
  localparam logic [4:0] OP_SHLLI  = 5'd4;
  localparam logic [4:0] OP_SHRLI  = 5'd5;
  localparam logic [4:0] OP_JUMP   = 5'd6;
  localparam logic [4:0] OP_JUMPL  = 5'd7;
  localparam logic [4:0] OP_JUMPG  = 5'd8;
  localparam logic [4:0] OP_JUMPE  = 5'd9;
  localparam logic [4:0] OP_JUMPNE = 5'd10;
  localparam logic [4:0] OP_CMP    = 5'd11;
  localparam logic [4:0] OP_LOAD   = 5'd12;
  localparam logic [4:0] OP_LOADI  = 5'd13;
  localparam logic [4:0] OP_STORE  = 5'd14;
  localparam logic [4:0] OP_MOV    = 5'd15;

  logic                 out_valid_q, out_valid_d;
  logic [4:0]           op_out_q, op_out_d;
  logic [REG_IDX_W-1:0] dest_out_q, dest_out_d;
  logic [DATA_W-1:0]    result_q, result_d;
  logic [DATA_W-1:0]    store_data_q, store_data_d;
  logic                 reg_we_q, reg_we_d;
  logic                 branch_taken_q, branch_taken_d;
  logic [DATA_W-1:0]    target_q, target_d;
  logic                 zf_q, zf_d, gf_q, gf_d, lf_q, lf_d;

  logic                 fire;
  logic                 mul_fire;
  logic [DATA_W-1:0]    dec_result;
  logic                 dec_we;
  logic                 dec_bt;
  logic [DATA_W-1:0]    dec_target;
  logic                 jump_cond;

`ifdef EXEC_MUL_EN
  localparam logic [4:0] OP_MUL = 5'd16;
  localparam int         CNT_W  = $clog2(DATA_W + 1);

  // state    | meaning
  // IDLE     | accepting instructions
  // MUL_RUN  | one shift-add step per cycle, then a final cycle to publish
  // MUL_HOLD | product ready, waiting for the output slot to free up
  typedef enum logic [1:0] {IDLE, MUL_RUN, MUL_HOLD} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]    acc_q, acc_d;
  logic [DATA_W-1:0]    mcand_q, mcand_d;
  logic [DATA_W-1:0]    mplier_q, mplier_d;
  logic [DATA_W-1:0]    mul_rs2_q, mul_rs2_d;
  logic [DATA_W-1:0]    mul_npc_q, mul_npc_d;
  logic [REG_IDX_W-1:0] mul_dest_q, mul_dest_d;
  logic                 slot_free;
  logic                 mul_done;

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q == IDLE) && slot_free;
  assign mul_fire  = in_valid && in_ready && (op == OP_MUL);
  assign mul_done  = slot_free && ((state_q == MUL_HOLD) ||
                                   ((state_q == MUL_RUN) && (cnt_q == '0)));
`else
  assign in_ready = !out_valid_q || out_ready;
  assign mul_fire = 1'b0;
`endif

  assign fire = in_valid && in_ready;

  always_comb begin
    dec_result = '0;
    dec_we     = 1'b0;
    dec_bt     = 1'b0;
    dec_target = npc;
    jump_cond  = 1'b0;
    case (op)
      OP_SUB:   begin dec_result = rs1_data - rs2_data;        dec_we = 1'b1; end
      OP_ADD:   begin dec_result = rs1_data + rs2_data;        dec_we = 1'b1; end
      OP_ADDI:  begin dec_result = rs1_data + DATA_W'(imm);    dec_we = 1'b1; end
      OP_SHLLI: begin
        dec_result = (32'(imm) >= DATA_W) ? '0 : (rs1_data << imm);
        dec_we     = 1'b1;
      end
      OP_SHRLI: begin
        dec_result = (32'(imm) >= DATA_W) ? '0 : (rs1_data >> imm);
        dec_we     = 1'b1;
      end
      OP_JUMP:  begin dec_bt = 1'b1; dec_target = npc + rs2_data; end
      OP_JUMPL, OP_JUMPG, OP_JUMPE, OP_JUMPNE: begin
        // Flags are read from the registers, which a CMP accepted one edge earlier has already updated
        jump_cond = (op == OP_JUMPL) ? lf_q :
                    (op == OP_JUMPG) ? gf_q :
                    (op == OP_JUMPE) ? zf_q : !zf_q;
        if (jump_cond) begin
          dec_bt     = 1'b1;
          dec_target = npc + DATA_W'(1) + DATA_W'($signed(imm));
        end
      end
      OP_LOAD:  begin dec_result = rs1_data;     dec_we = 1'b1; end
      OP_LOADI: begin dec_result = DATA_W'(imm); dec_we = 1'b1; end
      OP_STORE: dec_result = rs1_data;
      OP_MOV:   begin dec_result = rs2_data;     dec_we = 1'b1; end
      default:  ;
    endcase
  end

  always_comb begin
    out_valid_d    = out_valid_q && !out_ready;
    op_out_d       = op_out_q;
    dest_out_d     = dest_out_q;
    result_d       = result_q;
    store_data_d   = store_data_q;
    reg_we_d       = reg_we_q;
    branch_taken_d = branch_taken_q;
    target_d       = target_q;
    zf_d           = zf_q;
    gf_d           = gf_q;
    lf_d           = lf_q;

    if (fire && !mul_fire) begin
      out_valid_d    = 1'b1;
      op_out_d       = op;
      dest_out_d     = dest_in;
      result_d       = dec_result;
      store_data_d   = rs2_data;
      reg_we_d       = dec_we;
      branch_taken_d = dec_bt;
      target_d       = dec_target;
      if (op == OP_CMP) begin
        zf_d = (rs1_data == rs2_data);
        lf_d = ($signed(rs1_data) < $signed(rs2_data));
        gf_d = ($signed(rs1_data) > $signed(rs2_data));
      end
    end

`ifdef EXEC_MUL_EN
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    mul_rs2_d  = mul_rs2_q;
    mul_npc_d  = mul_npc_q;
    mul_dest_d = mul_dest_q;
    case (state_q)
      IDLE: if (mul_fire) begin
        state_d    = MUL_RUN;
        cnt_d      = CNT_W'(DATA_W);
        acc_d      = '0;
        mcand_d    = rs1_data;
        mplier_d   = rs2_data;
        mul_rs2_d  = rs2_data;
        mul_npc_d  = npc;
        mul_dest_d = dest_in;
      end
      MUL_RUN: begin
        if (cnt_q != '0) begin
          acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - 1'b1;
        end else if (!slot_free) begin
          state_d = MUL_HOLD;
        end
      end
      MUL_HOLD: ;
      default: state_d = IDLE;
    endcase
    if (mul_done) begin
      state_d        = IDLE;
      out_valid_d    = 1'b1;
      op_out_d       = OP_MUL;
      dest_out_d     = mul_dest_q;
      result_d       = acc_q;
      store_data_d   = mul_rs2_q;
      reg_we_d       = 1'b1;
      branch_taken_d = 1'b0;
      target_d       = mul_npc_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q    <= 1'b0;
      op_out_q       <= '0;
      dest_out_q     <= '0;
      result_q       <= '0;
      store_data_q   <= '0;
      reg_we_q       <= 1'b0;
      branch_taken_q <= 1'b0;
      target_q       <= '0;
      zf_q           <= 1'b0;
      gf_q           <= 1'b0;
      lf_q           <= 1'b0;
`ifdef EXEC_MUL_EN
      state_q        <= IDLE;
      cnt_q          <= '0;
      acc_q          <= '0;
      mcand_q        <= '0;
      mplier_q       <= '0;
      mul_rs2_q      <= '0;
      mul_npc_q      <= '0;
      mul_dest_q     <= '0;
`endif
    end else begin
      out_valid_q    <= out_valid_d;
      op_out_q       <= op_out_d;
      dest_out_q     <= dest_out_d;
      result_q       <= result_d;
      store_data_q   <= store_data_d;
      reg_we_q       <= reg_we_d;
      branch_taken_q <= branch_taken_d;
      target_q       <= target_d;
      zf_q           <= zf_d;
      gf_q           <= gf_d;
      lf_q           <= lf_d;
`ifdef EXEC_MUL_EN
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      mcand_q        <= mcand_d;
      mplier_q       <= mplier_d;
      mul_rs2_q      <= mul_rs2_d;
      mul_npc_q      <= mul_npc_d;
      mul_dest_q     <= mul_dest_d;
`endif
    end
  end

  assign out_valid    = out_valid_q;
  assign op_out       = op_out_q;
  assign dest_out     = dest_out_q;
  assign result       = result_q;
  assign store_data   = store_data_q;
  assign reg_we       = reg_we_q;
  assign branch_taken = branch_taken_q;
  assign target       = target_q;
  assign zf           = zf_q;
  assign gf           = gf_q;
  assign lf           = lf_q;

endmodule

// File: tb/tb_execute_pipe.sv
// tb_execute_pipe: directed and random stimulus for execute_pipe, checked against a transaction-level model.
// Exercises the multiplier when EXEC_MUL_EN is defined, otherwise checks opcode 16 behaves as NOP.
module tb_execute_pipe;
  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic [15:0] rs1_data, rs2_data, npc;
  logic [4:0]  dest_in;
  logic [6:0]  imm;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  op_out;
  logic [4:0]  dest_out;
  logic [15:0] result, store_data, target;
  logic        reg_we, branch_taken, zf, gf, lf;

  execute_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .npc(npc), .dest_in(dest_in), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .op_out(op_out), .dest_out(dest_out),
    .result(result), .store_data(store_data), .reg_we(reg_we), .branch_taken(branch_taken),
    .target(target), .zf(zf), .gf(gf), .lf(lf)
  );

`ifdef EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct {
    logic [4:0]  op;
    logic [4:0]  dest;
    logic [15:0] res;
    bit          res_def;
    logic [15:0] sd;
    logic        we;
    logic        bt;
    logic [15:0] tgt;
  } exp_t;

  exp_t expq[$];
  bit   m_zf, m_gf, m_lf;
  int   n_cmp, n_err, n_acc, n_con;
  int   lat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation still running, required to finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int to_signed16(input logic [15:0] v);
    return (int'(v) >= 32768) ? int'(v) - 65536 : int'(v);
  endfunction

  function automatic exp_t model(input logic [4:0] o, input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] pc, input logic [4:0] d, input logic [6:0] im);
    exp_t e;
    int   si;
    bit   cond;
    e.op = o; e.dest = d; e.res = '0; e.res_def = 0; e.sd = b; e.we = 0; e.bt = 0; e.tgt = pc;
    si = (int'(im) >= 64) ? int'(im) - 128 : int'(im);
    case (int'(o))
      1:  begin e.res = 16'(int'(a) - int'(b)); e.res_def = 1; e.we = 1; end
      2:  begin e.res = 16'(int'(a) + int'(b)); e.res_def = 1; e.we = 1; end
      3:  begin e.res = 16'(int'(a) + int'(im)); e.res_def = 1; e.we = 1; end
      4:  begin
        e.res = (int'(im) >= 16) ? 16'h0 : 16'(longint'(a) * (longint'(1) << im));
        e.res_def = 1; e.we = 1;
      end
      5:  begin
        e.res = (int'(im) >= 16) ? 16'h0 : 16'(int'(a) / (1 << im));
        e.res_def = 1; e.we = 1;
      end
      6:  begin e.bt = 1; e.tgt = 16'(int'(pc) + int'(b)); end
      7, 8, 9, 10: begin
        cond = (o == 5'd7) ? m_lf : (o == 5'd8) ? m_gf : (o == 5'd9) ? m_zf : !m_zf;
        if (cond) begin e.bt = 1; e.tgt = 16'(int'(pc) + 1 + si); end
      end
      12: begin e.res = a; e.res_def = 1; e.we = 1; end
      13: begin e.res = 16'(im); e.res_def = 1; e.we = 1; end
      14: begin e.res = a; e.res_def = 1; end
      15: begin e.res = b; e.res_def = 1; e.we = 1; end
      16: if (MUL_EN) begin e.res = 16'(longint'(a) * longint'(b)); e.res_def = 1; e.we = 1; end
      default: ;
    endcase
    return e;
  endfunction

  // One clock: check flags, score a consumed result, record an accepted instruction, advance.
  task automatic tick();
    exp_t e;
    #1;
    chk("zf", zf, m_zf);
    chk("gf", gf, m_gf);
    chk("lf", lf, m_lf);
    if (out_valid && out_ready) begin
      n_con++;
      if (expq.size() == 0) chk("unexpected_out", out_valid, 1'b0);
      else begin
        e = expq.pop_front();
        chk("op_out", op_out, e.op);
        chk("dest_out", dest_out, e.dest);
        chk("store_data", store_data, e.sd);
        chk("reg_we", reg_we, e.we);
        chk("branch_taken", branch_taken, e.bt);
        chk("target", target, e.tgt);
        if (e.res_def) chk("result", result, e.res);
      end
    end
    if (in_valid && in_ready) begin
      n_acc++;
      expq.push_back(model(op, rs1_data, rs2_data, npc, dest_in, imm));
      if (op == 5'd11) begin
        m_zf = (rs1_data == rs2_data);
        m_lf = to_signed16(rs1_data) < to_signed16(rs2_data);
        m_gf = to_signed16(rs1_data) > to_signed16(rs2_data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] pc, input logic [4:0] d, input logic [6:0] im);
    in_valid = 1'b1; op = o; rs1_data = a; rs2_data = b; npc = pc; dest_in = d; imm = im;
  endtask

  task automatic model_reset();
    expq.delete();
    m_zf = 0; m_gf = 0; m_lf = 0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; n_acc = 0; n_con = 0;
    model_reset();
    reset = 1'b1; out_ready = 1'b1;
    // a transfer offered during reset must be dropped
    drive(5'd2, 16'h1111, 16'h2222, 16'h0040, 5'd9, 7'd3);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    model_reset();

    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_result", result, 16'h0);
    chk("rst_store_data", store_data, 16'h0);
    chk("rst_target", target, 16'h0);
    chk("rst_op_out", op_out, 5'h0);
    chk("rst_dest_out", dest_out, 5'h0);
    chk("rst_reg_we", reg_we, 1'b0);
    chk("rst_branch", branch_taken, 1'b0);
    chk("rst_flags", {zf, gf, lf}, 3'b000);

    drive(5'd2, 16'hFFFF, 16'h0002, 16'h0100, 5'd3, 7'd0);
    tick();
    chk("add_valid", out_valid, 1'b1);
    chk("add_result", result, 16'h0001);
    chk("add_we", reg_we, 1'b1);
    in_valid = 1'b0;
    tick();
    chk("add_consumed", out_valid, 1'b0);

    drive(5'd11, 16'hFFFE, 16'h0001, 16'h0000, 5'd1, 7'd0);
    tick();
    drive(5'd7, 16'h0000, 16'h0000, 16'h0010, 5'd2, 7'h7E);
    tick();
    chk("cmp_lf", lf, 1'b1);
    chk("cmp_gf", gf, 1'b0);
    chk("cmp_zf", zf, 1'b0);
    chk("jumpl_taken", branch_taken, 1'b1);
    chk("jumpl_target", target, 16'h000F);
    in_valid = 1'b0;
    tick();

    drive(5'd4, 16'h0001, 16'h0000, 16'h0000, 5'd4, 7'd16);
    tick();
    chk("shl16_result", result, 16'h0000);
    drive(5'd4, 16'h0001, 16'h0000, 16'h0000, 5'd4, 7'd15);
    tick();
    chk("shl15_result", result, 16'h8000);
    in_valid = 1'b0;
    tick();

    drive(5'd2, 16'd10, 16'd20, 16'h0200, 5'd5, 7'd0);
    tick();
    drive(5'd1, 16'd7, 16'd9, 16'h0300, 5'd6, 7'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_hold", result, expq[0].res);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stream_in_ready", in_ready, 1'b1);
      chk("stream_valid", out_valid, 1'b1);
      tick();
      drive(5'd3, 16'(i * 300), 16'(i), 16'(i + 64), 5'(i), 7'(i * 5));
    end
    in_valid = 1'b0;
    tick();
    tick();

`ifdef EXEC_MUL_EN
    drive(5'd16, 16'h0003, 16'h0005, 16'h0020, 5'd7, 7'd0);
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      chk("mul_in_ready", in_ready, 1'b0);
      tick();
      lat++;
    end
    chk("mul_latency", lat, 17);
    chk("mul_result", result, 16'h000F);
    chk("mul_we", reg_we, 1'b1);
    tick();

    drive(5'd16, 16'h1234, 16'h0007, 16'h0030, 5'd8, 7'd0);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    chk("abort_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 25; i++) begin
      chk("abort_no_out", out_valid, 1'b0);
      tick();
    end
`else
    drive(5'd16, 16'h0003, 16'h0005, 16'h0020, 5'd7, 7'd0);
    tick();
    chk("op16_valid", out_valid, 1'b1);
    chk("op16_we", reg_we, 1'b0);
    chk("op16_op_out", op_out, 5'd16);
    in_valid = 1'b0;
    tick();
`endif

    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 3) != 0);
      op        = ($urandom_range(0, 99) < 90) ? 5'($urandom_range(0, 16)) : 5'($urandom_range(17, 31));
      rs1_data  = 16'($urandom());
      rs2_data  = ($urandom_range(0, 3) == 0) ? rs1_data : 16'($urandom());
      npc       = 16'($urandom());
      dest_in   = 5'($urandom());
      imm       = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(14, 18)) : 7'($urandom());
      tick();
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 100 && expq.size() > 0; k++) tick();
    chk("drain_empty", expq.size(), 0);
    chk("no_loss", n_con, n_acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
